pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 16-bit PMIPS pipelined core. It decides stall, bubble and flush for each cycle, and selects the PC source. It also holds a small 2-bit branch history table (BHT) for ID-stage prediction. It freezes the pipeline while the data-memory/IO device reports busy, with a timeout watchdog. It sits between the decode/EX stage signals and the PC, IF/ID and ID/EX register enables.

Parameters:
IDX_W, 2, BHT index width; table has 2**IDX_W entries indexed by pc[IDX_W:1]
PC_W, 16, PC width
REG_W, 3, register specifier width (8 registers, $0 hardwired zero)
MEM_TIMEOUT, 15, max consecutive freeze cycles per busy episode (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
id_rs  in  REG_W  ID source reg 1
id_rt  in  REG_W  ID source reg 2
id_uses_rt  in  1  ID instruction reads rt
id_branch  in  1  ID instruction is a conditional branch
id_pc  in  PC_W  PC of ID instruction
ex_memread  in  1  EX instruction is a load
ex_rd  in  REG_W  EX destination reg
ex_branch  in  1  EX holds a resolved branch
ex_pc  in  PC_W  PC of EX branch
ex_taken  in  1  actual outcome of EX branch
ex_predicted  in  1  prediction carried down with EX branch
dmem_busy  in  1  data memory/IO access not complete
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
idex_bubble  out  1  load NOP into ID/EX
ifid_flush  out  1  clear IF/ID
idex_flush  out  1  clear ID/EX
mem_stall  out  1  freeze all pipeline registers
predict_taken  out  1  ID branch predicted taken
pc_src  out  2  00 PC+2, 01 predicted target, 10 redirect to EX target, 11 redirect to ex_pc+2
mem_err  out  1  sticky memory-timeout flag
mispredict_cnt  out  16  saturating mispredict count
state  out  2  debug: 00 RUN, 01 MEMWAIT

Behaviour:
- Clocking and reset
  - One clock, synchronous active-high reset.
  - While reset=1, all control outputs are 0 and pc_src=00.
  - On the reset edge: BHT entries go to 01 (weak not-taken), state goes to RUN, the wait counter goes to 0, mem_err goes to 0, mispredict_cnt goes to 0.
  - Reset mid-freeze or mid-timeout aborts immediately.
- Priority (combinational, same cycle): mem freeze > mispredict > load-use > prediction. A lower-priority event's outputs are 0 when a higher one is active.
- Mem freeze
  - Condition: freeze = dmem_busy & ~mem_err.
  - Outputs when freeze: mem_stall=1, pc_stall=1, ifid_stall=1; all flush, bubble and prediction outputs 0; pc_src=00.
  - No BHT update and no mispredict_cnt change during freeze.
- Mispredict
  - Condition: ex_branch & (ex_taken != ex_predicted).
  - Outputs: ifid_flush=1, idex_flush=1, pc_src=10 if ex_taken else 11.
  - mispredict_cnt increments at the edge, saturating at 0xFFFF.
- Load-use
  - Condition: ex_memread & ex_rd != 0 & (ex_rd == id_rs | (id_uses_rt & ex_rd == id_rt)).
  - Outputs: pc_stall=1, ifid_stall=1, idex_bubble=1. Lasts one cycle, because the bubble clears EX.
- Prediction
  - predict_taken = id_branch & BHT[id_pc idx][1]; pc_src=01 when predict_taken and no higher event is active.
  - predict_taken is forced 0 whenever load-use or mispredict is active.
- BHT update
  - Happens at the edge when ex_branch & ~freeze.
  - Counter at ex_pc idx: increment if ex_taken, else decrement; saturate at 00 and 11.
  - If a read and a write hit the same entry in one cycle, the read returns the old value.
- State machine
  - RUN -> MEMWAIT when freeze.
  - MEMWAIT -> RUN when ~dmem_busy.
  - Wait counter counts freeze cycles in the episode. If dmem_busy is still 1 after MEM_TIMEOUT freeze cycles, then at that edge mem_err is set and the state returns to RUN.
  - Freeze is therefore at most MEM_TIMEOUT cycles. Afterwards dmem_busy is ignored until reset.
  - The counter clears on return to RUN.
- Held EX events re-evaluate on the first unfrozen cycle.

Test Plan:
- Load-use: ex_memread=1, ex_rd=3, id_rs=3 -> for 1 cycle pc_stall=ifid_stall=idex_bubble=1; ex_rd=0 with id_rs=0 -> no stall; id_rt=3 with id_uses_rt=0 -> no stall.
- Predictor training: after reset, id_branch at pc 0x0004 -> predict_taken=0; two EX taken resolves at 0x0004 -> BHT=11, predict_taken=1, pc_src=01; entry for 0x0006 is unaffected.
- Mispredict: ex_branch=1, ex_taken=1, ex_predicted=0, with a simultaneous load-use condition -> ifid_flush=idex_flush=1, pc_src=10, no bubble, mispredict_cnt 0->1; ex_taken=0, ex_predicted=1 -> pc_src=11.
- Mem freeze: dmem_busy high 3 cycles with a mispredict pending in EX -> mem_stall=1 for 3 cycles, no flush, cnt unchanged; on cycle 4 the flush fires and cnt increments.
- Timeout: dmem_busy held high 20 cycles, MEM_TIMEOUT=15 -> mem_stall=1 for exactly 15 cycles, then mem_err=1, state=00, mem_stall=0 thereafter.
- Reset during MEMWAIT at cycle 5 -> next cycle state=00, mem_err=0, all BHT entries=01, mispredict_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the PMIPS core: stall/bubble/flush decisions,
// PC source select, 2-bit branch history table and a data-memory freeze watchdog.
//
//   state   | meaning
//   RUN     | pipeline advancing normally (or frozen on the first busy cycle)
//   MEMWAIT | pipeline frozen while dmem_busy, wait counter running
module pipe_hazard_ctrl #(
  parameter int IDX_W       = 2,
  parameter int PC_W        = 16,
  parameter int REG_W       = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic [PC_W-1:0]  id_pc,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic             ex_predicted,
  input  logic             dmem_busy,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_stall,
  output logic             predict_taken,
  output logic [1:0]       pc_src,
  output logic             mem_err,
  output logic [15:0]      mispredict_cnt,
  output logic [1:0]       state
);

  localparam int N_ENT = 1 << IDX_W;
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt, wait_d;
  logic [1:0]         bht [N_ENT];
  logic [IDX_W-1:0]   id_idx, ex_idx;
  logic [1:0]         bht_rd;
  logic               freeze, mispredict, load_use, timeout, bht_hint;
  logic               unused_pc_bits;

  assign id_idx  = id_pc[IDX_W:1];
  assign ex_idx  = ex_pc[IDX_W:1];
  assign bht_rd  = bht[id_idx];
  assign unused_pc_bits = ^{id_pc[PC_W-1:IDX_W+1], id_pc[0], ex_pc[PC_W-1:IDX_W+1], ex_pc[0]};

  assign freeze     = dmem_busy & ~mem_err;
  assign mispredict = ex_branch & (ex_taken != ex_predicted);
  assign load_use   = ex_memread & (ex_rd != '0) &
                      ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  assign bht_hint   = id_branch & bht_rd[1];
  // wait_cnt holds completed freeze cycles, so this is the last permitted one
  assign timeout    = freeze & (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
      if (timeout) mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      RUN: begin
        if (freeze && !timeout) begin
          state_d = MEMWAIT;
          wait_d  = wait_cnt + CNT_W'(1);
        end
      end
      MEMWAIT: begin
        if (timeout || !dmem_busy) begin
          state_d = RUN;
        end else begin
          wait_d = wait_cnt + CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    idex_bubble   = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    mem_stall     = 1'b0;
    predict_taken = 1'b0;
    pc_src        = 2'b00;
    if (reset) begin
      pc_src = 2'b00;
    end else if (freeze) begin
      mem_stall  = 1'b1;
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
    end else if (mispredict) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pc_src     = ex_taken ? 2'b10 : 2'b11;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end else if (bht_hint) begin
      predict_taken = 1'b1;
      pc_src        = 2'b01;
    end
  end

  assign state = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_ENT; i++) bht[i] <= 2'b01;
    end else if (ex_branch && !freeze) begin
      if (ex_taken && bht[ex_idx] != 2'b11)
        bht[ex_idx] <= bht[ex_idx] + 2'b01;
      else if (!ex_taken && bht[ex_idx] != 2'b00)
        bht[ex_idx] <= bht[ex_idx] - 2'b01;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      mispredict_cnt <= '0;
    else if (mispredict && !freeze && mispredict_cnt != 16'hFFFF)
      mispredict_cnt <= mispredict_cnt + 16'd1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected outputs are queued as each
// step is driven and popped for comparison mid-cycle.
module tb_pipe_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rt, id_branch, ex_memread, ex_branch, ex_taken, ex_predicted, dmem_busy;
  logic [15:0] id_pc, ex_pc;
  logic        pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush, mem_stall, predict_taken;
  logic [1:0]  pc_src, state;
  logic        mem_err;
  logic [15:0] mispredict_cnt;

  pipe_hazard_ctrl #(.IDX_W(2), .PC_W(16), .REG_W(3), .MEM_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_branch(id_branch), .id_pc(id_pc),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch(ex_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_predicted(ex_predicted), .dmem_busy(dmem_busy),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .mem_stall(mem_stall),
    .predict_taken(predict_taken), .pc_src(pc_src), .mem_err(mem_err),
    .mispredict_cnt(mispredict_cnt), .state(state)
  );

  always #5 clock = ~clock;

  // {pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush, mem_stall, predict_taken, pc_src}
  localparam logic [8:0] NONE = 9'b000_000_0_00;
  localparam logic [8:0] LU   = 9'b111_000_0_00;
  localparam logic [8:0] MP10 = 9'b000_110_0_10;
  localparam logic [8:0] MP11 = 9'b000_110_0_11;
  localparam logic [8:0] FRZ  = 9'b110_001_0_00;
  localparam logic [8:0] PRED = 9'b000_000_1_01;

  typedef struct {
    string       tag;
    logic [8:0]  ctl;
    logic        err;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic [15:0] mcnt;

  task automatic cyc();
    @(posedge clock);
    #1;
    reset = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_branch = 1'b0; id_pc = '0;
    ex_memread = 1'b0; ex_rd = '0; ex_branch = 1'b0; ex_pc = '0; ex_taken = 1'b0;
    ex_predicted = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic step(input string tag, input logic [8:0] ctl, input logic err,
                      input logic [1:0] st, input logic [15:0] cnt);
    exp_t e;
    logic [27:0] obs, expv;
    sb.push_back('{tag, ctl, err, st, cnt});
    #4;
    e    = sb.pop_front();
    obs  = {pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush, mem_stall,
            predict_taken, pc_src, mem_err, state, mispredict_cnt};
    expv = {e.ctl, e.err, e.st, e.cnt};
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed ctl=%b err=%b st=%b cnt=%h expected ctl=%b err=%b st=%b cnt=%h",
             e.tag, obs[27:19], obs[18], obs[17:16], obs[15:0], e.ctl, e.err, e.st, e.cnt);
    end
  endtask

  task automatic mispred(input logic taken, input logic [15:0] pc);
    ex_branch = 1'b1; ex_taken = taken; ex_predicted = ~taken; ex_pc = pc;
  endtask

  initial begin
    reset = 1'b1; dmem_busy = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1; ex_predicted = 1'b0;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_branch = 1'b0; id_pc = '0;
    ex_memread = 1'b0; ex_rd = '0; ex_pc = '0;
    mcnt = 16'd0;

    // reset holds every control output low even with busy + mispredict present
    cyc(); reset = 1'b1; dmem_busy = 1'b1; mispred(1'b1, 16'h0008);
    step("reset_outputs", NONE, 1'b0, 2'b00, 16'd0);

    // load-use
    cyc(); ex_memread = 1'b1; ex_rd = 3'd3; id_rs = 3'd3;
    step("load_use_rs", LU, 1'b0, 2'b00, mcnt);
    cyc();
    step("load_use_done", NONE, 1'b0, 2'b00, mcnt);
    cyc(); ex_memread = 1'b1; ex_rd = 3'd0; id_rs = 3'd0;
    step("load_use_r0", NONE, 1'b0, 2'b00, mcnt);
    cyc(); ex_memread = 1'b1; ex_rd = 3'd3; id_rs = 3'd1; id_rt = 3'd3; id_uses_rt = 1'b0;
    step("load_use_rt_unused", NONE, 1'b0, 2'b00, mcnt);
    cyc(); ex_memread = 1'b1; ex_rd = 3'd3; id_rs = 3'd1; id_rt = 3'd3; id_uses_rt = 1'b1;
    step("load_use_rt", LU, 1'b0, 2'b00, mcnt);

    // predictor training at 0x0004 (idx 2)
    cyc(); id_branch = 1'b1; id_pc = 16'h0004;
    step("pred_cold", NONE, 1'b0, 2'b00, mcnt);
    cyc(); id_branch = 1'b1; id_pc = 16'h0004;
    ex_branch = 1'b1; ex_pc = 16'h0004; ex_taken = 1'b1; ex_predicted = 1'b1;
    step("pred_read_old", NONE, 1'b0, 2'b00, mcnt);
    cyc(); ex_branch = 1'b1; ex_pc = 16'h0004; ex_taken = 1'b1; ex_predicted = 1'b1;
    cyc(); id_branch = 1'b1; id_pc = 16'h0004;
    step("pred_trained", PRED, 1'b0, 2'b00, mcnt);
    cyc(); id_branch = 1'b1; id_pc = 16'h0006;
    step("pred_neighbor", NONE, 1'b0, 2'b00, mcnt);

    // mispredict beats simultaneous load-use and prediction
    cyc(); mispred(1'b1, 16'h0008);
    ex_memread = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_branch = 1'b1; id_pc = 16'h0004;
    step("mispred_taken", MP10, 1'b0, 2'b00, mcnt);
    mcnt++;
    cyc(); mispred(1'b0, 16'h0008);
    step("mispred_not_taken", MP11, 1'b0, 2'b00, mcnt);
    mcnt++;
    cyc();
    step("mispred_cnt", NONE, 1'b0, 2'b00, mcnt);

    // freeze holds a pending mispredict at 0x0006 (idx 3) for three cycles
    for (int i = 0; i < 3; i++) begin
      cyc(); dmem_busy = 1'b1; mispred(1'b1, 16'h0006);
      step($sformatf("freeze_%0d", i), FRZ, 1'b0, (i == 0) ? 2'b00 : 2'b01, mcnt);
    end
    cyc(); mispred(1'b1, 16'h0006);
    step("freeze_release", MP10, 1'b0, 2'b01, mcnt);
    mcnt++;
    cyc(); ex_branch = 1'b1; ex_pc = 16'h0006; ex_taken = 1'b0; ex_predicted = 1'b0;
    step("freeze_after", NONE, 1'b0, 2'b00, mcnt);
    // idx 3 went 01 -> 10 -> 01 only if the frozen cycles left the table alone
    cyc(); id_branch = 1'b1; id_pc = 16'h0006;
    step("freeze_no_bht_upd", NONE, 1'b0, 2'b00, mcnt);

    // watchdog: busy for 20 cycles, only 15 frozen
    for (int i = 0; i < 20; i++) begin
      cyc(); dmem_busy = 1'b1;
      step($sformatf("timeout_%0d", i), (i < 15) ? FRZ : NONE, (i >= 15) ? 1'b1 : 1'b0,
           (i >= 1 && i < 15) ? 2'b01 : 2'b00, mcnt);
    end
    cyc(); dmem_busy = 1'b1; mispred(1'b1, 16'h0008);
    step("busy_ignored", MP10, 1'b1, 2'b00, mcnt);
    mcnt++;

    // clean up, then reset in the middle of a freeze episode
    cyc(); reset = 1'b1;
    step("reset_again", NONE, 1'b1, 2'b00, mcnt);
    mcnt = 16'd0;
    cyc(); mispred(1'b1, 16'h0004);
    step("pre_wait_mispred", MP10, 1'b0, 2'b00, mcnt);
    mcnt++;
    for (int i = 0; i < 4; i++) begin
      cyc(); dmem_busy = 1'b1;
      step($sformatf("wait_%0d", i), FRZ, 1'b0, (i == 0) ? 2'b00 : 2'b01, mcnt);
    end
    cyc(); dmem_busy = 1'b1; reset = 1'b1;
    step("reset_in_wait", NONE, 1'b0, 2'b01, mcnt);
    mcnt = 16'd0;
    cyc(); id_branch = 1'b1; id_pc = 16'h0004;
    step("post_reset_idx2", NONE, 1'b0, 2'b00, mcnt);
    cyc(); id_branch = 1'b1; id_pc = 16'h0008;
    step("post_reset_idx0", NONE, 1'b0, 2'b00, mcnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
